// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one registered 4:1 data mux among four requesters.
// A hold limit forces rotation when a requester keeps the mux while others wait.
module rr_mux_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] i_0,
   input  logic [DATA_W-1:0] i_1,
   input  logic [DATA_W-1:0] i_2,
   input  logic [DATA_W-1:0] i_3,
   output logic [3:0]        gnt,
   output logic [1:0]        sel,
   output logic [DATA_W-1:0] mux_out,
   output logic              out_valid,
   output logic              busy
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   state_e            state_q, state_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        last_q, last_d;
   logic [7:0]        hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0] mux_out_q, mux_out_d;
   logic              out_valid_q, out_valid_d;

   logic [1:0]        win;
   logic [3:0]        others;
   logic              cur_req;
   logic [DATA_W-1:0] sel_data;

   // First requester found scanning last+1, last+2, ... with wrap.
   // The last step revisits "last" itself, so it only wins when alone.
   function automatic logic [1:0] rr_pick(
      input logic [3:0] r,
      input logic [1:0] last
   );
      logic [1:0] idx;
      logic [1:0] w;
      logic       found;
      w     = last;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && r[idx]) begin
            w     = idx;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   always_comb begin
      win     = rr_pick(req, last_q);
      others  = req & ~gnt_q;
      cur_req = |(req & gnt_q);
   end

   always_comb begin
      sel_data = i_0;
      unique case (sel_q)
         2'd0: sel_data = i_0;
         2'd1: sel_data = i_1;
         2'd2: sel_data = i_2;
         2'd3: sel_data = i_3;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      sel_d       = sel_q;
      last_d      = last_q;
      hold_cnt_d  = hold_cnt_q;
      mux_out_d   = mux_out_q;
      out_valid_d = 1'b0;

      // A transfer needs both the grant and a still-asserted request.
      if (cur_req) begin
         out_valid_d = 1'b1;
         mux_out_d   = sel_data;
      end

      unique case (state_q)
         IDLE: begin
            gnt_d = 4'b0000;
            if (|req) begin
               state_d    = GRANT;
               gnt_d      = 4'b0001 << win;
               sel_d      = win;
               last_d     = win;
               hold_cnt_d = 8'd1;
            end
         end
         GRANT: begin
            if (!cur_req) begin
               if (|others) begin
                  gnt_d      = 4'b0001 << win;
                  sel_d      = win;
                  last_d     = win;
                  hold_cnt_d = 8'd1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
               end
            end else if (hold_cnt_q >= HOLD_MAX && |others) begin
               gnt_d      = 4'b0001 << win;
               sel_d      = win;
               last_d     = win;
               hold_cnt_d = 8'd1;
            end else if (hold_cnt_q < HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 4'b0000;
         sel_q       <= 2'd0;
         last_q      <= 2'd3;
         hold_cnt_q  <= 8'd0;
         mux_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         mux_out_q   <= mux_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign mux_out   = mux_out_q;
   assign out_valid = out_valid_q;
   assign busy      = |gnt_q;

`ifndef SYNTHESIS
   a_gnt_onehot: assert property (
      @(posedge clk) disable iff (!rst_n)
      $onehot0(gnt_q)
   );

   a_sel_match: assert property (
      @(posedge clk) disable iff (!rst_n)
      (gnt_q != 4'b0000) |-> gnt_q[sel_q]
   );

   a_grant_state: assert property (
      @(posedge clk) disable iff (!rst_n)
      (state_q == GRANT) == (gnt_q != 4'b0000)
   );
`endif

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter that shares one 4:1 data multiplexer between four requesters. It picks a requester, drives the one-hot grant and the 2-bit mux select, and registers the selected input onto a single shared output. A hold limit bounds how long one requester may keep the mux while others are waiting. It sits in front of any shared single-lane resource fed by four sources.

Parameters:
DATA_W, 8, width of each data input and of mux_out
MAX_HOLD, 4, max consecutive grant cycles per requester while another request is pending; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; bit k belongs to requester k
i_0  input  DATA_W  data from requester 0
i_1  input  DATA_W  data from requester 1
i_2  input  DATA_W  data from requester 2
i_3  input  DATA_W  data from requester 3
gnt  output  4  one-hot grant, registered; all zero when idle
sel  output  2  mux select, registered; encodes the granted index
mux_out  output  DATA_W  registered selected data
out_valid  output  1  mux_out holds a transferred word this cycle
busy  output  1  high when gnt is nonzero

Behaviour:
- Reset (async, rst_n=0): gnt=0, sel=0, mux_out=0, out_valid=0, busy=0, state=IDLE, last=3, hold_cnt=0. Outputs clear immediately, not at the next edge. Reset mid-grant drops the grant with no completion.
- State machine has two states: IDLE and GRANT.
- Round-robin search: scan indices (last+1) mod 4, (last+2) mod 4, and so on, wrapping. The first index with req set wins. After reset, requester 0 has top priority.
- IDLE, req nonzero at edge: next cycle gnt=onehot(w), sel=w, last=w, hold_cnt=1, state=GRANT. Latency from req to gnt is 1 cycle.
- IDLE, req zero: remain in IDLE; gnt=0; sel and mux_out hold their last values.
- GRANT to k: each edge evaluates in this priority order.
  a) req[k]=0: release. If any other req is set, grant the RR winner next cycle with hold_cnt=1 and no idle bubble. Otherwise gnt=0 and go to IDLE.
  b) req[k]=1, hold_cnt==MAX_HOLD, and another req is set: force a switch to the RR winner, which is never k. Set hold_cnt=1.
  c) Otherwise keep k and increment hold_cnt. hold_cnt saturates at MAX_HOLD. With no competitor, k keeps the mux indefinitely.
- Transfer: a cycle with gnt[k]=1 and req[k]=1 is a transfer. On the next edge, mux_out <= i_k and out_valid <= 1. Otherwise out_valid <= 0 and mux_out holds.
- gnt may stay high for one cycle after req[k] falls (req is sampled at the edge). No transfer is counted in that cycle.
- gnt is always zero or one-hot. sel equals the encoded gnt whenever gnt is nonzero.
- No combinational path exists from req or i_* to any output.

Test Plan:
1. Fairness with all four requests held, MAX_HOLD=4: req=4'b1111 continuously. Required gnt: 0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then back to 0001. Switches have no bubble, and out_valid stays 1 from the cycle after the first grant.
2. Lone requester: req=4'b0100 held for 10 cycles. Required: gnt=0100 and sel=2 for all 10 cycles with no rotation. gnt=0 one cycle after req drops, then busy=0.
3. Simultaneous request and handover from reset: req=4'b1010. First gnt=0010. Drop req[1]; the next cycle gnt=1000 directly. Drop req[3]; gnt goes to 0 and state is IDLE.
4. Data path: grant held on 2 with i_2=8'hA5 at cycle t and i_2=8'h3C at t+1. Required: mux_out=A5 at t+1 and 3C at t+2, with out_valid=1 in both. In the gnt-high/req-low trailing cycle, out_valid=0 and mux_out holds.
5. Pointer wrap: after a grant to 3 ends, set req=4'b1001. Required: gnt=0001. Then with req=4'b1001 held, grant 0 ends and gnt=1000.
6. Async reset mid-grant: assert rst_n=0 between edges while gnt=0100. Required: all outputs read 0 before the next edge. After release with req=4'b1100, first gnt=0100, confirming last was reset to 3.
